// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants for the data-memory arbiter and its helpers.
//   Size codes  : BYTE, HALF_WORD, WORD (2'b11 is illegal)
//   FSM states  : IDLE, ACCESS
//   Master ids  : M0 (load/store unit), M1 (DMA/debug)
package dmem_pkg;

  localparam logic [1:0] BYTE      = 2'b00;
  localparam logic [1:0] HALF_WORD = 2'b01;
  localparam logic [1:0] WORD      = 2'b10;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requesting master's access channel into dmem_arbiter.
//   Req, WE, Size, SignEx, Addr, WrData : request, held stable until Ack
//   Ack, RdData, Err                    : one-cycle completion response
// Modports: master (requester side), slave (arbiter side).
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          Req;
  logic          WE;
  logic [1:0]    Size;
  logic          SignEx;
  logic [AW-1:0] Addr;
  logic [DW-1:0] WrData;
  logic          Ack;
  logic [DW-1:0] RdData;
  logic          Err;

  modport master (
    output Req, WE, Size, SignEx, Addr, WrData,
    input  Ack, RdData, Err
  );

  modport slave (
    input  Req, WE, Size, SignEx, Addr, WrData,
    output Ack, RdData, Err
  );
endinterface

// File: rtl/dmem_align_chk.sv
// dmem_align_chk: combinational alignment check for a memory access.
//   i_Size       in 2 : access size code
//   i_AddrLo     in 2 : low two byte-address bits
//   o_Misaligned out 1: half-word on odd address, word not on a 4-byte
//                       boundary, or illegal size code
module dmem_align_chk
  import dmem_pkg::*;
(
  input  logic [1:0] i_Size,
  input  logic [1:0] i_AddrLo,
  output logic       o_Misaligned
);

  always_comb begin
    o_Misaligned = 1'b0;
    case (i_Size)
      BYTE:      o_Misaligned = 1'b0;
      HALF_WORD: o_Misaligned = i_AddrLo[0];
      WORD:      o_Misaligned = |i_AddrLo;
      default:   o_Misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter/sequencer in front of the single DMEM port.
// Each granted access is latched, driven onto DMEM for one cycle (ACCESS),
// then answered with a registered Ack/RdData/Err pulse.
//   i_Clk, i_Rst (async, active-low)
//   m0, m1   : dmem_arbiter_if.slave request channels
//   o_fWE, o_fRE, o_Size, o_fSignEx, o_Addr, o_Data : DMEM controls
//   i_Data   : DMEM combinational read data
// Build option: DMEM_ARB_RR_EN selects round-robin tie-breaking; when
// undefined, M0 always wins ties and no pointer register exists.
//
// state  | meaning
// IDLE   | DMEM outputs 0, waiting for an eligible request
// ACCESS | latched command on DMEM for one cycle, response registered
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  dmem_arbiter_if.slave m0,
  dmem_arbiter_if.slave m1,
  output logic          o_fWE,
  output logic          o_fRE,
  output logic [1:0]    o_Size,
  output logic          o_fSignEx,
  output logic [AW-1:0] o_Addr,
  output logic [DW-1:0] o_Data,
  input  logic [DW-1:0] i_Data
);

  state_t        state, stateNext;

  logic          cmdWE, cmdSignEx, cmdMis, cmdId;
  logic [1:0]    cmdSize;
  logic [AW-1:0] cmdAddr;
  logic [DW-1:0] cmdData;

  logic          ack0Q, ack1Q, err0Q, err1Q;
  logic [DW-1:0] rd0Q, rd1Q;

  logic          elig0, elig1, grant, winId, winMis;
  logic          winWE, winSignEx;
  logic [1:0]    winSize;
  logic [AW-1:0] winAddr;
  logic [DW-1:0] winData;

  // A request still high during its own Ack cycle is the finished one.
  assign elig0 = m0.Req & ~ack0Q;
  assign elig1 = m1.Req & ~ack1Q;
  assign grant = elig0 | elig1;

`ifdef DMEM_ARB_RR_EN
  logic lastId;

  // Tie goes to whoever was not served last.
  always_comb begin
    winId = elig0 ? M0 : M1;
    if (elig0 && elig1) winId = ~lastId;
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst)                        lastId <= M1;
    else if (state == IDLE && grant)   lastId <= winId;
  end
`else
  assign winId = elig0 ? M0 : M1;
`endif

  assign winWE     = (winId == M1) ? m1.WE     : m0.WE;
  assign winSize   = (winId == M1) ? m1.Size   : m0.Size;
  assign winSignEx = (winId == M1) ? m1.SignEx : m0.SignEx;
  assign winAddr   = (winId == M1) ? m1.Addr   : m0.Addr;
  assign winData   = (winId == M1) ? m1.WrData : m0.WrData;

  dmem_align_chk uAlignChk (
    .i_Size      (winSize),
    .i_AddrLo    (winAddr[1:0]),
    .o_Misaligned(winMis)
  );

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) state <= IDLE;
    else        state <= stateNext;
  end

  // DMEM side is fully zeroed outside ACCESS; a misaligned command keeps
  // both enables low so DMEM is never touched.
  always_comb begin
    stateNext = state;
    o_fWE     = 1'b0;
    o_fRE     = 1'b0;
    o_Size    = 2'b00;
    o_fSignEx = 1'b0;
    o_Addr    = '0;
    o_Data    = '0;
    case (state)
      IDLE: begin
        if (grant) stateNext = ACCESS;
      end
      ACCESS: begin
        o_fWE     = cmdWE & ~cmdMis;
        o_fRE     = ~cmdWE & ~cmdMis;
        o_Size    = cmdSize;
        o_fSignEx = cmdSignEx;
        o_Addr    = cmdAddr;
        o_Data    = cmdData;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      cmdWE     <= 1'b0;
      cmdSignEx <= 1'b0;
      cmdMis    <= 1'b0;
      cmdId     <= M0;
      cmdSize   <= 2'b00;
      cmdAddr   <= '0;
      cmdData   <= '0;
    end else if (state == IDLE && grant) begin
      cmdWE     <= winWE;
      cmdSignEx <= winSignEx;
      cmdMis    <= winMis;
      cmdId     <= winId;
      cmdSize   <= winSize;
      cmdAddr   <= winAddr;
      cmdData   <= winData;
    end
  end

  // Responses are single-cycle pulses; RdData is cleared whenever Ack is low.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      ack0Q <= 1'b0;
      ack1Q <= 1'b0;
      err0Q <= 1'b0;
      err1Q <= 1'b0;
      rd0Q  <= '0;
      rd1Q  <= '0;
    end else begin
      ack0Q <= 1'b0;
      ack1Q <= 1'b0;
      err0Q <= 1'b0;
      err1Q <= 1'b0;
      rd0Q  <= '0;
      rd1Q  <= '0;
      if (state == ACCESS) begin
        if (cmdId == M0) begin
          ack0Q <= 1'b1;
          err0Q <= cmdMis;
          rd0Q  <= (!cmdWE && !cmdMis) ? i_Data : '0;
        end else begin
          ack1Q <= 1'b1;
          err1Q <= cmdMis;
          rd1Q  <= (!cmdWE && !cmdMis) ? i_Data : '0;
        end
      end
    end
  end

  assign m0.Ack    = ack0Q;
  assign m0.Err    = err0Q;
  assign m0.RdData = rd0Q;
  assign m1.Ack    = ack1Q;
  assign m1.Err    = err1Q;
  assign m1.RdData = rd1Q;

endmodule
